serial_adder: RTL and testbench

SERIAL_ADDER -- requirements
Module: serial_adder

---
 rtl/serial_adder_pkg.sv | 14 +
 rtl/serial_adder_full_adder.sv | 25 ++
 rtl/serial_adder.sv | 134 +++++++++++++
 tb/tb_serial_adder.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/serial_adder_pkg.sv
// -----------------------------------------------------------------------------
// serial_adder_pkg
// Shared definitions for the bit-serial adder: FSM state type and encodings.
// No ports; imported by serial_adder.
// -----------------------------------------------------------------------------
package serial_adder_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'b00;
  localparam state_t ST_SHIFT = 2'b01;
  localparam state_t ST_DONE  = 2'b10;

endpackage : serial_adder_pkg

// File: rtl/serial_adder_full_adder.sv
// -----------------------------------------------------------------------------
// full_adder
// Single-bit full-adder cell used for each serial bit step.
// Ports:
//   x, y : operand bits
//   z    : carry-in bit
//   S    : sum bit
//   C    : carry-out bit
// -----------------------------------------------------------------------------
module full_adder (
  input  logic x,
  input  logic y,
  input  logic z,
  output logic C,
  output logic S
);

  logic w_xy;

  assign w_xy = x ^ y;
  assign S    = w_xy ^ z;
  // Carry: generate when both operands set, propagate the incoming carry otherwise.
  assign C    = (x & y) | (z & w_xy);

endmodule : full_adder

// File: rtl/serial_adder.sv
// -----------------------------------------------------------------------------
// serial_adder
// Bit-serial adder: one full-adder cell processes WIDTH bits LSB first, one bit
// per clock. Result (a+b+cin) mod 2^WIDTH and carry-out are captured into
// registered outputs when the last bit is processed, flagged by a one-cycle
// done pulse.
// Parameters:
//   WIDTH : operand/sum width in bits (2..32)
// Ports:
//   clk   : clock, rising-edge
//   rst_n : synchronous active-low reset
//   start : begin an addition (honoured only in IDLE)
//   a, b  : operands, sampled on the accepting edge
//   cin   : carry-in, sampled on the accepting edge
//   busy  : high while bits are being shifted through the adder cell
//   done  : one-cycle pulse marking a new result on sum/cout
//   sum   : registered result
//   cout  : registered carry-out
// -----------------------------------------------------------------------------
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int                CNT_W     = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0]  LAST_STEP = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);

  state_t             r_state;
  logic [WIDTH-1:0]   r_a_sr;
  logic [WIDTH-1:0]   r_b_sr;
  logic [WIDTH-1:0]   r_s_sr;
  logic               r_carry;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_busy;
  logic               r_done;
  logic [WIDTH-1:0]   r_sum;
  logic               r_cout;

  logic               w_fa_s;
  logic               w_fa_c;
  logic               w_last;
  logic [WIDTH-1:0]   w_s_next;

  full_adder u_fa (
    .x (r_a_sr[0]),
    .y (r_b_sr[0]),
    .z (r_carry),
    .C (w_fa_c),
    .S (w_fa_s)
  );

  // Sum bits enter at the MSB so after WIDTH steps bit 0 holds the first
  // (least significant) result bit.
  assign w_s_next = {w_fa_s, r_s_sr[WIDTH-1:1]};
  assign w_last   = (r_cnt == LAST_STEP);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_a_sr  <= '0;
      r_b_sr  <= '0;
      r_s_sr  <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_a_sr  <= a;
            r_b_sr  <= b;
            r_s_sr  <= '0;
            r_carry <= cin;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= ST_SHIFT;
          end
        end

        ST_SHIFT: begin
          r_a_sr  <= {1'b0, r_a_sr[WIDTH-1:1]};
          r_b_sr  <= {1'b0, r_b_sr[WIDTH-1:1]};
          r_s_sr  <= w_s_next;
          r_carry <= w_fa_c;
          // Counter tops out at WIDTH, which fits in CNT_W bits, so it never wraps.
          r_cnt   <= r_cnt + CNT_ONE;
          if (w_last) begin
            // Capture straight from the adder cell so the result lands on the
            // same edge as the final bit step.
            r_sum   <= w_s_next;
            r_cout  <= w_fa_c;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= ST_DONE;
          end
        end

        ST_DONE: begin
          r_done  <= 1'b0;
          r_state <= ST_IDLE;
        end

        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign sum  = r_sum;
  assign cout = r_cout;

endmodule : serial_adder

// File: tb/tb_serial_adder.sv
// -----------------------------------------------------------------------------
// tb_serial_adder
// Directed bench for serial_adder: an 8-bit instance and a 4-bit instance
// sharing clock and reset.
// -----------------------------------------------------------------------------
module tb_serial_adder;

  logic       clk;
  logic       rst_n;

  logic       start8, cin8;
  logic [7:0] a8, b8;
  logic       busy8, done8, cout8;
  logic [7:0] sum8;

  logic       start4, cin4;
  logic [3:0] a4, b4;
  logic       busy4, done4, cout4;
  logic [3:0] sum4;

  int         checks;
  int         errors;
  logic [7:0] hold_sum;
  logic       hold_cout;

  logic [7:0] ta  [3];
  logic [7:0] tb  [3];
  logic       tc  [3];
  logic [7:0] ts  [3];
  logic       tco [3];

  serial_adder #(.WIDTH(8)) u_dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start8),
    .a     (a8),
    .b     (b8),
    .cin   (cin8),
    .busy  (busy8),
    .done  (done8),
    .sum   (sum8),
    .cout  (cout8)
  );

  serial_adder #(.WIDTH(4)) u_dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start4),
    .a     (a4),
    .b     (b4),
    .cin   (cin4),
    .busy  (busy4),
    .done  (done4),
    .sum   (sum4),
    .cout  (cout4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One 8-bit operation from IDLE; optionally scrambles inputs while shifting.
  task automatic run_op8(input logic [7:0] ia, input logic [7:0] ib, input logic ic,
                         input logic [7:0] es, input logic ec, input bit scramble,
                         input string tag);
    a8 = ia; b8 = ib; cin8 = ic; start8 = 1'b1;
    tick;
    start8 = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      chk($sformatf("%s_busy_c%0d", tag, i), {31'd0, busy8}, 32'd1);
      chk($sformatf("%s_done_c%0d", tag, i), {31'd0, done8}, 32'd0);
      chk($sformatf("%s_sumhold_c%0d", tag, i), {24'd0, sum8}, {24'd0, hold_sum});
      chk($sformatf("%s_couthold_c%0d", tag, i), {31'd0, cout8}, {31'd0, hold_cout});
      if (scramble) begin
        a8     = 8'($urandom);
        b8     = 8'($urandom);
        cin8   = 1'($urandom_range(0, 1));
        start8 = 1'($urandom_range(0, 1));
      end
      tick;
    end
    start8 = 1'b0;
    chk({tag, "_done"}, {31'd0, done8}, 32'd1);
    chk({tag, "_busy_end"}, {31'd0, busy8}, 32'd0);
    chk({tag, "_sum"}, {24'd0, sum8}, {24'd0, es});
    chk({tag, "_cout"}, {31'd0, cout8}, {31'd0, ec});
    hold_sum  = es;
    hold_cout = ec;
    tick;
    chk({tag, "_done_fall"}, {31'd0, done8}, 32'd0);
    chk({tag, "_busy_idle"}, {31'd0, busy8}, 32'd0);
    chk({tag, "_sum_after"}, {24'd0, sum8}, {24'd0, hold_sum});
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    checks = 0; errors = 0;
    rst_n = 1'b0;
    start8 = 1'b0; a8 = 8'h00; b8 = 8'h00; cin8 = 1'b0;
    start4 = 1'b0; a4 = 4'h0;  b4 = 4'h0;  cin4 = 1'b0;
    hold_sum = 8'h00; hold_cout = 1'b0;

    ta[0] = 8'h12; tb[0] = 8'h34; tc[0] = 1'b0; ts[0] = 8'h46; tco[0] = 1'b0;
    ta[1] = 8'hF0; tb[1] = 8'h20; tc[1] = 1'b1; ts[1] = 8'h11; tco[1] = 1'b1;
    ta[2] = 8'hAA; tb[2] = 8'h55; tc[2] = 1'b1; ts[2] = 8'h00; tco[2] = 1'b1;

    // Reset state, with start asserted to confirm reset wins.
    start8 = 1'b1; start4 = 1'b1;
    tick;
    tick;
    chk("rst_busy8", {31'd0, busy8}, 32'd0);
    chk("rst_done8", {31'd0, done8}, 32'd0);
    chk("rst_sum8",  {24'd0, sum8},  32'd0);
    chk("rst_cout8", {31'd0, cout8}, 32'd0);
    chk("rst_busy4", {31'd0, busy4}, 32'd0);
    chk("rst_done4", {31'd0, done4}, 32'd0);
    chk("rst_sum4",  {28'd0, sum4},  32'd0);
    chk("rst_cout4", {31'd0, cout4}, 32'd0);
    start8 = 1'b0; start4 = 1'b0;
    rst_n = 1'b1;

    // First start accepted on the first edge after release.
    run_op8(8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, "zero");
    run_op8(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, "ff_01");
    run_op8(8'h7F, 8'h80, 1'b1, 8'h00, 1'b1, 1'b0, "7f_80_c");
    run_op8(8'hA5, 8'h5A, 1'b0, 8'hFF, 1'b0, 1'b0, "a5_5a");
    run_op8(8'h35, 8'h4A, 1'b0, 8'h7F, 1'b0, 1'b1, "scramble");

    // Reset in the middle of an operation.
    a8 = 8'hC3; b8 = 8'h3C; cin8 = 1'b1; start8 = 1'b1;
    tick;
    start8 = 1'b0;
    tick; tick; tick;
    chk("abort_busy_pre", {31'd0, busy8}, 32'd1);
    rst_n = 1'b0;
    tick;
    chk("abort_busy", {31'd0, busy8}, 32'd0);
    chk("abort_done", {31'd0, done8}, 32'd0);
    chk("abort_sum",  {24'd0, sum8},  32'd0);
    chk("abort_cout", {31'd0, cout8}, 32'd0);
    tick;
    chk("abort_done2", {31'd0, done8}, 32'd0);
    rst_n = 1'b1;
    hold_sum = 8'h00; hold_cout = 1'b0;
    run_op8(8'h01, 8'h02, 1'b0, 8'h03, 1'b0, 1'b0, "post_rst");

    // start held high: one acceptance every 10 edges, other cycles present noise.
    for (int cyc = 0; cyc < 30; cyc++) begin
      start8 = 1'b1;
      if (cyc % 10 == 0) begin
        a8 = ta[cyc/10]; b8 = tb[cyc/10]; cin8 = tc[cyc/10];
      end else begin
        a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom_range(0, 1));
      end
      tick;
      chk($sformatf("cont_busy_%0d", cyc + 1), {31'd0, busy8},
          {31'd0, (((cyc + 1) % 10) >= 1) && (((cyc + 1) % 10) <= 8)});
      chk($sformatf("cont_done_%0d", cyc + 1), {31'd0, done8},
          {31'd0, ((cyc + 1) % 10) == 9});
      if ((cyc + 1) % 10 == 9) begin
        chk($sformatf("cont_sum_%0d", cyc / 10), {24'd0, sum8}, {24'd0, ts[cyc/10]});
        chk($sformatf("cont_cout_%0d", cyc / 10), {31'd0, cout8}, {31'd0, tco[cyc/10]});
      end
    end
    start8 = 1'b0;
    tick;
    chk("cont_idle_busy", {31'd0, busy8}, 32'd0);

    // 4-bit instance: F + F + 1.
    a4 = 4'hF; b4 = 4'hF; cin4 = 1'b1; start4 = 1'b1;
    tick;
    start4 = 1'b0; a4 = 4'h0; b4 = 4'h0; cin4 = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      chk($sformatf("w4_busy_c%0d", i), {31'd0, busy4}, 32'd1);
      chk($sformatf("w4_done_c%0d", i), {31'd0, done4}, 32'd0);
      tick;
    end
    chk("w4_done", {31'd0, done4}, 32'd1);
    chk("w4_busy_end", {31'd0, busy4}, 32'd0);
    chk("w4_sum",  {28'd0, sum4},  32'hF);
    chk("w4_cout", {31'd0, cout4}, 32'd1);
    tick;
    chk("w4_done_fall", {31'd0, done4}, 32'd0);
    chk("w4_sum_hold",  {28'd0, sum4},  32'hF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_serial_adder
